// File: rtl/picobello_noc_link_slice.sv
// Elastic 2-entry register slice for the req, rsp and wide channels of one mesh link direction.
// Optional perf counters are built only when PB_LINK_PERF_CNT_EN is defined.

// state | meaning
// Empty | no entry held, valid_o=0, ready_o=1
// One   | head entry held, valid_o=1, ready_o=1
// Full  | head and tail held, valid_o=1, ready_o=0
module picobello_noc_link_slice_chan #(
  parameter int unsigned Width    = 64,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [Width-1:0]    data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [Width-1:0]    data_o,
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] flits_o,
  output logic [CntWidth-1:0] stalls_o
);

  // Encoding puts valid_o in bit 1 and ready_o in bit 0, so both come straight from flops.
  typedef enum logic [1:0] {
    Empty = 2'b01,
    One   = 2'b11,
    Full  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  head_q, tail_q;
  logic              push, pop;
  logic              load_head_in, load_head_tail, load_tail;

  assign valid_o = state_q[1];
  assign ready_o = state_q[0];
  assign data_o  = head_q;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Empty;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      Empty: begin
        if (push) begin
          state_d      = One;
          load_head_in = 1'b1;
        end
      end
      One: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_d   = Full;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = Empty;
        end
      end
      Full: begin
        if (pop) begin
          state_d        = One;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = Empty;
    endcase
  end

  // Payload flops carry no reset; contents are don't-care while valid_o=0.
  always_ff @(posedge clk_i) begin
    if (load_head_in)        head_q <= data_i;
    else if (load_head_tail) head_q <= tail_q;
    if (load_tail)           tail_q <= data_i;
  end

`ifdef PB_LINK_PERF_CNT_EN
  logic [CntWidth-1:0] flits_q, stalls_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      flits_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop)                 flits_q  <= flits_q + 1'b1;
      if (valid_o && !ready_i) stalls_q <= stalls_q + 1'b1;
    end
  end

  assign flits_o  = flits_q;
  assign stalls_o = stalls_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign flits_o        = '0;
  assign stalls_o       = '0;
`endif

endmodule

module picobello_noc_link_slice #(
  parameter int unsigned ReqWidth  = 64,
  parameter int unsigned RspWidth  = 64,
  parameter int unsigned WideWidth = 512,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ReqWidth-1:0]  req_data_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [ReqWidth-1:0]  req_data_o,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [RspWidth-1:0]  rsp_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [RspWidth-1:0]  rsp_data_o,
  input  logic                 wide_valid_i,
  output logic                 wide_ready_o,
  input  logic [WideWidth-1:0] wide_data_i,
  output logic                 wide_valid_o,
  input  logic                 wide_ready_i,
  output logic [WideWidth-1:0] wide_data_o,
  input  logic                 cnt_clr_i,
  output logic [CntWidth-1:0]  req_flits_o,
  output logic [CntWidth-1:0]  req_stalls_o,
  output logic [CntWidth-1:0]  rsp_flits_o,
  output logic [CntWidth-1:0]  rsp_stalls_o,
  output logic [CntWidth-1:0]  wide_flits_o,
  output logic [CntWidth-1:0]  wide_stalls_o
);

  picobello_noc_link_slice_chan #(.Width(ReqWidth), .CntWidth(CntWidth)) i_req (
    .clk_i, .rst_i,
    .valid_i  (req_valid_i),  .ready_o (req_ready_o), .data_i (req_data_i),
    .valid_o  (req_valid_o),  .ready_i (req_ready_i), .data_o (req_data_o),
    .cnt_clr_i,
    .flits_o  (req_flits_o),  .stalls_o (req_stalls_o)
  );

  picobello_noc_link_slice_chan #(.Width(RspWidth), .CntWidth(CntWidth)) i_rsp (
    .clk_i, .rst_i,
    .valid_i  (rsp_valid_i),  .ready_o (rsp_ready_o), .data_i (rsp_data_i),
    .valid_o  (rsp_valid_o),  .ready_i (rsp_ready_i), .data_o (rsp_data_o),
    .cnt_clr_i,
    .flits_o  (rsp_flits_o),  .stalls_o (rsp_stalls_o)
  );

  picobello_noc_link_slice_chan #(.Width(WideWidth), .CntWidth(CntWidth)) i_wide (
    .clk_i, .rst_i,
    .valid_i  (wide_valid_i), .ready_o (wide_ready_o), .data_i (wide_data_i),
    .valid_o  (wide_valid_o), .ready_i (wide_ready_i), .data_o (wide_data_o),
    .cnt_clr_i,
    .flits_o  (wide_flits_o), .stalls_o (wide_stalls_o)
  );

endmodule

// File: tb/tb_picobello_noc_link_slice.sv
// Directed bench for picobello_noc_link_slice; counter expectations follow PB_LINK_PERF_CNT_EN.
module tb_picobello_noc_link_slice;

  localparam int unsigned CW = 4;

  logic          clk_i, rst_i, cnt_clr_i;
  logic          req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [63:0]   req_data_i, req_data_o;
  logic          rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic [63:0]   rsp_data_i, rsp_data_o;
  logic          wide_valid_i, wide_ready_o, wide_valid_o, wide_ready_i;
  logic [511:0]  wide_data_i, wide_data_o;
  logic [CW-1:0] req_flits_o, req_stalls_o, rsp_flits_o, rsp_stalls_o, wide_flits_o, wide_stalls_o;

  int checks   = 0;
  int failures = 0;

  picobello_noc_link_slice #(.ReqWidth(64), .RspWidth(64), .WideWidth(512), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_data_o(req_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .wide_valid_i(wide_valid_i), .wide_ready_o(wide_ready_o), .wide_data_i(wide_data_i),
    .wide_valid_o(wide_valid_o), .wide_ready_i(wide_ready_i), .wide_data_o(wide_data_o),
    .cnt_clr_i(cnt_clr_i),
    .req_flits_o(req_flits_o), .req_stalls_o(req_stalls_o),
    .rsp_flits_o(rsp_flits_o), .rsp_stalls_o(rsp_stalls_o),
    .wide_flits_o(wide_flits_o), .wide_stalls_o(wide_stalls_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vi;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic        er;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ecnt(input int m);
    logic [CW-1:0] r;
    r = CW'(m % 16);
`ifndef PB_LINK_PERF_CNT_EN
    r = '0;
`endif
    return r;
  endfunction

  function automatic logic [511:0] wval(input int i);
    logic [63:0] w;
    w = 64'hC0DE_0000_0000_0000 | 64'(i);
    return {8{w}};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_all(input string tag);
    chk({tag, " req_valid"}, 512'(req_valid_o), 512'(0));
    chk({tag, " rsp_valid"}, 512'(rsp_valid_o), 512'(0));
    chk({tag, " wide_valid"}, 512'(wide_valid_o), 512'(0));
    chk({tag, " req_ready"}, 512'(req_ready_o), 512'(1));
    chk({tag, " rsp_ready"}, 512'(rsp_ready_o), 512'(1));
    chk({tag, " wide_ready"}, 512'(wide_ready_o), 512'(1));
    chk({tag, " req_flits"}, 512'(req_flits_o), 512'(0));
    chk({tag, " req_stalls"}, 512'(req_stalls_o), 512'(0));
    chk({tag, " rsp_flits"}, 512'(rsp_flits_o), 512'(0));
    chk({tag, " rsp_stalls"}, 512'(rsp_stalls_o), 512'(0));
    chk({tag, " wide_flits"}, 512'(wide_flits_o), 512'(0));
    chk({tag, " wide_stalls"}, 512'(wide_stalls_o), 512'(0));
  endtask

  initial begin
    int m_f, m_s;

    // streaming A0..A9, then backpressure, then ONE-state push+pop
    for (int k = 0; k < 10; k++)
      vecs[k] = '{1'b1, 64'hA0 + 64'(k), 1'b1, (k > 0), 1'b1, 64'hA0 + 64'(k) - 64'd1};
    vecs[10] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA9};
    vecs[11] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0};
    vecs[12] = '{1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[13] = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 64'h11};
    vecs[14] = '{1'b1, 64'h33, 1'b0, 1'b1, 1'b0, 64'h11};
    vecs[15] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h11};
    vecs[16] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h22};
    vecs[17] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0};
    vecs[18] = '{1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[19] = '{1'b1, 64'h44, 1'b1, 1'b1, 1'b1, 64'h55};
    vecs[20] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h44};
    vecs[21] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h44};
    vecs[22] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h44};
    vecs[23] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0};

    rst_i = 1'b1; cnt_clr_i = 1'b0;
    req_valid_i = 0;  req_ready_i = 0;  req_data_i = '0;
    rsp_valid_i = 0;  rsp_ready_i = 0;  rsp_data_i = '0;
    wide_valid_i = 0; wide_ready_i = 0; wide_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_all("reset");
    cyc();

    m_f = 0; m_s = 0;
    for (int k = 0; k < 24; k++) begin
      req_valid_i = vecs[k].vi; req_data_i = vecs[k].d; req_ready_i = vecs[k].rdy;
      @(negedge clk_i);
      chk($sformatf("vec%0d req_valid", k), 512'(req_valid_o), 512'(vecs[k].ev));
      chk($sformatf("vec%0d req_ready", k), 512'(req_ready_o), 512'(vecs[k].er));
      if (vecs[k].ev)
        chk($sformatf("vec%0d req_data", k), 512'(req_data_o), 512'(vecs[k].ed));
      chk($sformatf("vec%0d req_flits", k), 512'(req_flits_o), 512'(ecnt(m_f)));
      chk($sformatf("vec%0d req_stalls", k), 512'(req_stalls_o), 512'(ecnt(m_s)));
      chk($sformatf("vec%0d rsp_valid", k), 512'(rsp_valid_o), 512'(0));
      if (vecs[k].ev && vecs[k].rdy)  m_f++;
      if (vecs[k].ev && !vecs[k].rdy) m_s++;
      cyc();
    end
    req_valid_i = 0; req_ready_i = 0;

    // independence: wide stalled while req/rsp stream
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    wide_valid_i = 1; wide_data_i = wval(0); wide_ready_i = 0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      req_valid_i = 1; req_data_i = 64'h100 + 64'(i); req_ready_i = 1;
      rsp_valid_i = 1; rsp_data_i = 64'h200 + 64'(i); rsp_ready_i = 1;
      wide_valid_i = 1; wide_data_i = wval(i + 1); wide_ready_i = 0;
      @(negedge clk_i);
      if (i > 0) begin
        chk($sformatf("ind%0d req_valid", i), 512'(req_valid_o), 512'(1));
        chk($sformatf("ind%0d req_data", i), 512'(req_data_o), 512'(64'h100 + 64'(i - 1)));
        chk($sformatf("ind%0d rsp_data", i), 512'(rsp_data_o), 512'(64'h200 + 64'(i - 1)));
      end
      chk($sformatf("ind%0d req_ready", i), 512'(req_ready_o), 512'(1));
      chk($sformatf("ind%0d wide_ready", i), 512'(wide_ready_o), 512'(i == 0));
      chk($sformatf("ind%0d wide_data", i), wide_data_o, wval(0));
      cyc();
    end
    req_valid_i = 0; rsp_valid_i = 0; wide_valid_i = 0;
    @(negedge clk_i);
    chk("ind wide_stalls", 512'(wide_stalls_o), 512'(ecnt(20)));
    chk("ind wide_flits", 512'(wide_flits_o), 512'(ecnt(0)));
    chk("ind req_flits", 512'(req_flits_o), 512'(ecnt(19)));
    chk("ind rsp_flits", 512'(rsp_flits_o), 512'(ecnt(19)));
    chk("ind req_data_last", 512'(req_data_o), 512'(64'h113));
    cyc();

    // fill every channel, then reset mid-operation
    req_ready_i = 0; rsp_ready_i = 0; wide_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid_i = 1;  req_data_i = 64'h300 + 64'(i);
      rsp_valid_i = 1;  rsp_data_i = 64'h400 + 64'(i);
      wide_valid_i = 1; wide_data_i = wval(64 + i);
      cyc();
    end
    @(negedge clk_i);
    chk("full req_ready", 512'(req_ready_o), 512'(0));
    chk("full rsp_ready", 512'(rsp_ready_o), 512'(0));
    chk("full wide_ready", 512'(wide_ready_o), 512'(0));
    chk("full req_head", 512'(req_data_o), 512'(64'h300));
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    req_valid_i = 1; req_data_i = 64'hB0; req_ready_i = 1;
    rsp_valid_i = 0; wide_valid_i = 0;
    @(negedge clk_i);
    chk_idle_all("midrst");
    cyc();
    req_valid_i = 0;
    @(negedge clk_i);
    chk("midrst first_valid", 512'(req_valid_o), 512'(1));
    chk("midrst first_data", 512'(req_data_o), 512'(64'hB0));
    cyc();

    // counter wrap and clear priority
    cnt_clr_i = 1; cyc(); cnt_clr_i = 0;
    for (int i = 0; i < 17; i++) begin
      req_valid_i = 1; req_data_i = 64'h500 + 64'(i);
      cyc();
    end
    req_valid_i = 0;
    cyc();
    @(negedge clk_i);
    chk("wrap req_flits", 512'(req_flits_o), 512'(ecnt(17)));
    chk("wrap req_stalls", 512'(req_stalls_o), 512'(ecnt(0)));
    cyc();
    req_valid_i = 1; req_data_i = 64'h600;
    cyc();
    req_valid_i = 0; cnt_clr_i = 1;
    @(negedge clk_i);
    chk("clr pop_valid", 512'(req_valid_o), 512'(1));
    cyc();
    cnt_clr_i = 0;
    @(negedge clk_i);
    chk("clr req_flits", 512'(req_flits_o), 512'(0));
    chk("clr req_valid", 512'(req_valid_o), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
